led_status_code: RTL

- Drives the example design's two status LEDs: one blinks a 4-bit status code as N blinks followed by a dark gap, the other stretches short activity pulses (e.g. FIFO byte strobes) into a visible on-time.
- Sits alongside the heartbeat blinker at the FPGA top, downstream of the FIFO/loopback logic that produces the status code and activity strobes.
- Uses the same time base as the heartbeat: a free-running half-period counter derived from CLK_FREQ/BLINK_FREQ.

---
 rtl/led_status_code.sv | 122 ++++++++++++
 1 files changed

// File: rtl/led_status_code.sv
// led_status_code
//   Drives two status LEDs from one shared half-period tick.
//   led_code blinks the 4-bit status code as N blinks followed by a dark gap.
//   led_act stretches short activity strobes into a visible on-time.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   code      status code to display, 0 = dark
//   act_in    activity strobe, any width
//   led_code  code blink LED (registered)
//   led_act   activity LED (registered)
//   busy      code sequence in progress, state != IDLE (registered)
//
// Code FSM states
//   state | meaning
//   IDLE  | dark, latches code on the next tick
//   ON    | LED lit for one tick, one blink consumed
//   OFF   | dark between blinks
//   GAP   | dark gap after the last blink
module led_status_code #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BLINK_FREQ    = 5,
    parameter int GAP_TICKS     = 4,
    parameter int STRETCH_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    input  logic       act_in,
    output logic       led_code,
    output logic       led_act,
    output logic       busy
);

    localparam int          CYCLES = CLK_FREQ / 2 / BLINK_FREQ;
    localparam logic [31:0] CYC_M1 = 32'(CYCLES - 1);
    localparam int          GW     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int          AW     = $clog2(STRETCH_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    logic [31:0]   count;
    logic          tick;
    state_t        state, state_nxt;
    logic [3:0]    remaining, remaining_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [AW-1:0] act_cnt, act_nxt;

    // count >= CYC_M1 rather than == keeps the counter self-recovering
    assign tick = (count >= CYC_M1);

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        gap_nxt       = gap_cnt;
        if (tick) begin
            case (state)
                IDLE: begin
                    remaining_nxt = code;
                    if (code != 4'd0) state_nxt = ON;
                end
                ON: begin
                    remaining_nxt = remaining - 4'd1;
                    state_nxt     = OFF;
                end
                OFF: begin
                    // testing for zero here is what keeps remaining from wrapping
                    if (remaining == 4'd0) begin
                        state_nxt = GAP;
                        gap_nxt   = GW'(GAP_TICKS - 1);
                    end else begin
                        state_nxt = ON;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state_nxt = IDLE;
                    else               gap_nxt   = gap_cnt - GW'(1);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // a fresh strobe wins over a simultaneous tick
    always_comb begin
        act_nxt = act_cnt;
        if (act_in)
            act_nxt = AW'(STRETCH_TICKS);
        else if (tick && act_cnt != '0)
            act_nxt = act_cnt - AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            state     <= IDLE;
            remaining <= '0;
            gap_cnt   <= '0;
            act_cnt   <= '0;
            led_code  <= 1'b0;
            led_act   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            count     <= tick ? '0 : count + 32'd1;
            state     <= state_nxt;
            remaining <= remaining_nxt;
            gap_cnt   <= gap_nxt;
            act_cnt   <= act_nxt;
            // LEDs follow the next-state values so they move with the state register
            led_code  <= (state_nxt == ON);
            busy      <= (state_nxt != IDLE);
            led_act   <= (act_nxt != '0);
        end
    end

endmodule
